// File: rtl/result_write_ctrl_pkg.sv
//------------------------------------------------------------------------------
// result_write_ctrl_pkg
// Types and constants shared by the result write sequencer.
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

`include "const.svh"

package result_write_ctrl_pkg;

    // Cache geometry and latency, taken from the system constants
    localparam int CACHE_ADDRW  = `CACHE_ADDRW;
    localparam int CACHE_RD_LAT = `CACHE_RD_LAT;

    // Default cache word width and the number of bytes it holds
    localparam int RESULT_DATAW   = 32;
    localparam int BYTES_PER_WORD = RESULT_DATAW / 8;

    // Sequencer states
    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_RD    = 3'd1,
        ST_WAIT1 = 3'd2,
        ST_WAIT2 = 3'd3,
        ST_SEND  = 3'd4,
        ST_GAP   = 3'd5,
        ST_FIN   = 3'd6
    } result_wr_state_t;

    // Bytes per cache word for an arbitrary data width
    function automatic int bytes_per_word(input int dataw);
        return dataw / 8;
    endfunction

endpackage

`default_nettype wire

// File: rtl/const.svh
//------------------------------------------------------------------------------
// const.svh
// Shared system-wide constants for the boot/IO path.
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
`ifndef CONST_SVH
`define CONST_SVH

// Instruction memory word-address width
`define INST_MEM_ADDRW 12
// Data cache word-address width
`define CACHE_ADDRW 12
// Cycles from cache read enable to valid read data
`define CACHE_RD_LAT 2

`endif

// File: rtl/word_byte_sel.sv
//------------------------------------------------------------------------------
// word_byte_sel
// Combinational little-endian byte selector: picks byte byte_idx of a word.
// Out-of-range indices (non power-of-two byte counts) return zero.
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module word_byte_sel
    import result_write_ctrl_pkg::*;
#(
    parameter int DATAW = RESULT_DATAW,
    parameter int IDXW  = $clog2(BYTES_PER_WORD)
) (
    input  logic [DATAW-1:0] word,
    input  logic [IDXW-1:0]  byte_idx,
    output logic [7:0]       byte_out
);

    localparam int NUM_BYTES = bytes_per_word(DATAW);

    // One-hot style mux over the byte lanes of the word
    always_comb begin
        byte_out = 8'h00;
        for (int i = 0; i < NUM_BYTES; i++) begin
            if (byte_idx == IDXW'(i)) begin
                byte_out = word[8*i +: 8];
            end
        end
    end

endmodule

`default_nettype wire

// File: rtl/result_write_ctrl.sv
//------------------------------------------------------------------------------
// result_write_ctrl
// Sequences the result write phase: reads result words from the data cache
// and streams them byte by byte (little-endian) to the AXI UART TX writer,
// then pulses done once the requested number of bytes has been accepted.
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module result_write_ctrl
    import result_write_ctrl_pkg::*;
#(
    parameter int ADDRW     = CACHE_ADDRW,
    parameter int DATAW     = RESULT_DATAW,
    parameter int BASE_ADDR = 0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [31:0]      result_bytes,
    output logic             cache_re,
    output logic [ADDRW-1:0] cache_addr,
    input  logic [DATAW-1:0] cache_rdata,
    output logic             axi_we,
    output logic [7:0]       axi_wdata,
    input  logic             axi_w_busy,
    input  logic             axi_w_success,
    output logic             busy,
    output logic             done
);

    localparam int NUM_BYTES = bytes_per_word(DATAW);
    localparam int IDXW      = (NUM_BYTES > 1) ? $clog2(NUM_BYTES) : 1;

    // Largest transfer the cache can source without the word address wrapping
    localparam logic [63:0]       MAX_BYTES = 64'(NUM_BYTES) << ADDRW;
    localparam logic [IDXW-1:0]   LAST_IDX  = IDXW'(NUM_BYTES - 1);
    localparam logic [ADDRW-1:0]  START_ADDR = ADDRW'(BASE_ADDR);

    // The wait states assume a fixed two-cycle cache and whole-byte words
    generate
        if ((DATAW % 8) != 0 || DATAW < 8) begin : g_bad_dataw
            $error("result_write_ctrl: DATAW must be a positive multiple of 8");
        end
        if (CACHE_RD_LAT != 2) begin : g_bad_rd_lat
            $error("result_write_ctrl: sequencer is built for a 2-cycle cache read");
        end
    endgenerate

    result_wr_state_t state;
    logic [31:0]      remaining;
    logic [ADDRW-1:0] addr;
    logic [DATAW-1:0] word;
    logic [IDXW-1:0]  byte_idx;
    logic [7:0]       sel_byte;
    logic [31:0]      clamped_bytes;

    // Cache address is the registered word pointer
    assign cache_addr = addr;

    // Byte lane of the held word that goes out next
    word_byte_sel #(
        .DATAW (DATAW),
        .IDXW  (IDXW)
    ) u_byte_sel (
        .word     (word),
        .byte_idx (byte_idx),
        .byte_out (sel_byte)
    );

    // Limit the requested byte count to what the cache can hold
    always_comb begin
        clamped_bytes = result_bytes;
        if ({32'd0, result_bytes} > MAX_BYTES) begin
            clamped_bytes = MAX_BYTES[31:0];
        end
    end

    // Main sequencer with registered outputs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= ST_IDLE;
            remaining <= 32'd0;
            addr      <= START_ADDR;
            word      <= '0;
            byte_idx  <= '0;
            cache_re  <= 1'b0;
            axi_we    <= 1'b0;
            axi_wdata <= 8'h00;
            busy      <= 1'b0;
            done      <= 1'b0;
        end else begin
            // Pulse outputs default low each cycle
            cache_re <= 1'b0;
            done     <= 1'b0;

            case (state)
                ST_IDLE: begin
                    if (start) begin
                        busy <= 1'b1;
                        if (result_bytes == 32'd0) begin
                            state <= ST_FIN;
                        end else begin
                            remaining <= clamped_bytes;
                            addr      <= START_ADDR;
                            cache_re  <= 1'b1;
                            state     <= ST_RD;
                        end
                    end
                end

                // cache_re is high for this single cycle
                ST_RD: begin
                    state <= ST_WAIT1;
                end

                ST_WAIT1: begin
                    state <= ST_WAIT2;
                end

                // Read data arrives two cycles after the enable
                ST_WAIT2: begin
                    word     <= cache_rdata;
                    byte_idx <= '0;
                    state    <= ST_GAP;
                end

                // Hold off the writer until it is free
                ST_GAP: begin
                    if (!axi_w_busy) begin
                        axi_we    <= 1'b1;
                        axi_wdata <= sel_byte;
                        state     <= ST_SEND;
                    end
                end

                // Keep the request and data steady until the byte is accepted
                ST_SEND: begin
                    if (axi_w_success) begin
                        axi_we    <= 1'b0;
                        remaining <= remaining - 32'd1;
                        if (remaining == 32'd1) begin
                            state <= ST_FIN;
                        end else if (byte_idx == LAST_IDX) begin
                            addr     <= addr + ADDRW'(1);
                            cache_re <= 1'b1;
                            state    <= ST_RD;
                        end else begin
                            byte_idx <= byte_idx + IDXW'(1);
                            state    <= ST_GAP;
                        end
                    end
                end

                ST_FIN: begin
                    done  <= 1'b1;
                    busy  <= 1'b0;
                    state <= ST_IDLE;
                end

                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

`default_nettype wire
